// File: rtl/frame_addr_ctrl.sv
// frame_addr_ctrl
// Configuration-stream front end for the per-column frame select stages.
// A header word (sync 8'hFA, column, frame index, burst flag, row count N)
// is followed by N data words. Each data word is forwarded as a one-cycle
// row write. After the last row write, the frame is committed with a
// single FrameStrobe pulse carrying the column and the one-hot frame index.
//
// Build option: FRAME_ADDR_BURST_EN
//   When defined, a header with burst=1 automatically advances to the next
//   frame of the same column after every strobe, reusing the column and the
//   row count, until the last frame of the column has been committed.
//   When undefined, the burst bit is ignored and every strobe returns to IDLE.
module frame_addr_ctrl #(
  parameter int MAX_FRAMES_PER_COL = 20,
  parameter int FRAME_SELECT_WIDTH = 5,
  parameter int NUM_COLS           = 18
) (
  input  logic                          CLK,
  input  logic                          resetn,
  input  logic [31:0]                   cfg_data,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  output logic [31:0]                   row_data,
  output logic [6:0]                    row_sel,
  output logic                          row_we,
  output logic [FRAME_SELECT_WIDTH-1:0] FrameSelect,
  output logic                          FrameStrobe,
  output logic [MAX_FRAMES_PER_COL-1:0] FrameStrobe_O,
  output logic                          busy,
  output logic                          err,
  input  logic                          err_clr
);

  localparam logic [7:0] SYNC_WORD    = 8'hFA;
  localparam logic [7:0] NUM_COLS_B   = 8'(NUM_COLS);
  localparam logic [7:0] MAX_FRAMES_B = 8'(MAX_FRAMES_PER_COL);

`ifdef FRAME_ADDR_BURST_EN
  localparam logic BURST_EN = 1'b1;
`else
  localparam logic BURST_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_STROBE = 2'd3
  } state_t;

  state_t state_r;
  state_t state_s;

  // Latched frame context
  logic [FRAME_SELECT_WIDTH-1:0] col_r;
  logic [7:0]                    frame_r;
  logic [6:0]                    rows_r;
  logic [6:0]                    cnt_r;
  logic                          burst_r;

  // Header field views of the incoming word
  logic [7:0] hdr_sync_s;
  logic [7:0] hdr_col_s;
  logic [7:0] hdr_frame_s;
  logic       hdr_burst_s;
  logic [6:0] hdr_rows_s;

  logic accept_s;
  logic hdr_ok_s;
  logic hdr_err_s;
  logic last_row_s;
  logic last_frame_s;
  logic burst_next_s;
  logic strobe_next_s;

  // One-hot decode of a frame index onto the frame strobe bus.
  function automatic logic [MAX_FRAMES_PER_COL-1:0] frame_onehot(input logic [7:0] idx);
    logic [MAX_FRAMES_PER_COL-1:0] oh;
    oh = {MAX_FRAMES_PER_COL{1'b0}};
    for (int i = 0; i < MAX_FRAMES_PER_COL; i++) begin
      oh[i] = (idx == 8'(i));
    end
    return oh;
  endfunction

  assign hdr_sync_s  = cfg_data[31:24];
  assign hdr_col_s   = cfg_data[23:16];
  assign hdr_frame_s = cfg_data[15:8];
  assign hdr_burst_s = cfg_data[7];
  assign hdr_rows_s  = cfg_data[6:0];

  // cfg_ready is a registered copy of "state is IDLE or DATA", so a plain
  // valid&ready is the word acceptance condition.
  assign accept_s = cfg_valid & cfg_ready;

  assign hdr_ok_s = (hdr_sync_s == SYNC_WORD) &&
                    (hdr_col_s < NUM_COLS_B) &&
                    (hdr_frame_s < MAX_FRAMES_B);

  // rows_r is never 0 while in DATA, so the subtraction cannot wrap there.
  assign last_row_s   = (cnt_r == (rows_r - 7'd1));
  assign last_frame_s = ((frame_r + 8'd1) == MAX_FRAMES_B);
  assign burst_next_s = BURST_EN & burst_r & ~last_frame_s;

  assign strobe_next_s = (state_s == ST_STROBE);

  // State register.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and header error detection.
  always_comb begin
    state_s   = state_r;
    hdr_err_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (!hdr_ok_s) begin
            // Rejected header: stay in IDLE, so the words that follow are
            // parsed as headers and never reach the row registers.
            hdr_err_s = 1'b1;
            state_s   = ST_IDLE;
          end else if (hdr_rows_s == 7'd0) begin
            state_s = ST_WAIT;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (accept_s && last_row_s) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_WAIT: begin
        state_s = ST_STROBE;
      end
      ST_STROBE: begin
        if (burst_next_s) begin
          if (rows_r == 7'd0) begin
            state_s = ST_WAIT;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Frame context: latch header fields, count rows, advance frame in burst.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      col_r   <= {FRAME_SELECT_WIDTH{1'b0}};
      frame_r <= 8'd0;
      rows_r  <= 7'd0;
      cnt_r   <= 7'd0;
      burst_r <= 1'b0;
    end else begin
      if ((state_r == ST_IDLE) && accept_s && hdr_ok_s) begin
        col_r   <= hdr_col_s[FRAME_SELECT_WIDTH-1:0];
        frame_r <= hdr_frame_s;
        rows_r  <= hdr_rows_s;
        cnt_r   <= 7'd0;
        burst_r <= hdr_burst_s;
      end else if ((state_r == ST_DATA) && accept_s) begin
        cnt_r <= cnt_r + 7'd1;
      end else if ((state_r == ST_STROBE) && burst_next_s) begin
        frame_r <= frame_r + 8'd1;
        cnt_r   <= 7'd0;
      end
    end
  end

  // Row write port: one-cycle pulse in the cycle after each data accept.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      row_data <= 32'd0;
      row_sel  <= 7'd0;
      row_we   <= 1'b0;
    end else begin
      row_we <= (state_r == ST_DATA) && accept_s;
      if ((state_r == ST_DATA) && accept_s) begin
        row_data <= cfg_data;
        row_sel  <= cnt_r;
      end
    end
  end

  // Frame commit outputs, driven only in the STROBE cycle.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      FrameStrobe   <= 1'b0;
      FrameSelect   <= {FRAME_SELECT_WIDTH{1'b0}};
      FrameStrobe_O <= {MAX_FRAMES_PER_COL{1'b0}};
    end else begin
      FrameStrobe <= strobe_next_s;
      if (strobe_next_s) begin
        FrameSelect   <= col_r;
        FrameStrobe_O <= frame_onehot(frame_r);
      end else begin
        FrameSelect   <= {FRAME_SELECT_WIDTH{1'b0}};
        FrameStrobe_O <= {MAX_FRAMES_PER_COL{1'b0}};
      end
    end
  end

  // Handshake and status outputs, registered from the next state.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      cfg_ready <= (state_s == ST_IDLE) || (state_s == ST_DATA);
      busy      <= (state_s != ST_IDLE);
    end
  end

  // Sticky error flag; a new header error wins over a same-cycle clear.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      err <= 1'b0;
    end else if (hdr_err_s) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end else begin
      err <= err;
    end
  end

endmodule
